rv32i_wb_ctrl: RTL and testbench
================================

# rv32i_wb_ctrl

Wishbone slave control block sitting directly upstream of the `iiitb_rv32i` core inside the user project. It lets the management SoC do three things:
- load instruction memory through an auto-incrementing address/data register pair;
- start and stop the core, and hold it in reset;
- read back the core's output register, a run-cycle counter and a sticky done flag.

It also raises `user_irq[0]` when the core signals completion.

## Interface
Parameters:
- `BASE_ADDR`, `32'h3000_0000`: Wishbone window base. Decode matches `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `IMEM_AW`, `8`: instruction-memory word-address width.

Ports:
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_ni` in 1: asynchronous active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic control.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `wbs_dat_o` out 32: read data.
- `core_rst_no` out 1: core reset, active-low.
- `imem_wr_en_o` out 1: imem write request.
- `imem_wr_addr_o` out `IMEM_AW`: imem write address.
- `imem_wr_data_o` out 32: imem write data.
- `imem_wr_ready_i` in 1: imem accepts the write on this edge when `en & ready`.
- `core_out_i` in 32: core output register.
- `core_done_i` in 1: core completion level.
- `irq_o` out 1: routed to `user_irq[0]`.

## Operation
Register map, by byte offset:
- **0x00 CTRL (RW)**
  - bit0 `RUN`.
  - bit1 `SRST`: write-1 pulse, reads 0. It clears `RUN` and the done flag and resets the counter.
- **0x04 STATUS (RO)**
  - bit0 running.
  - bit1 `DONE` (sticky; write 1 to 0x04 bit1 clears it).
  - bit2 imem write pending.
- **0x08 IMEM_ADDR (RW)**: `[IMEM_AW-1:0]`; upper bits read 0.
- **0x0C IMEM_DATA (WO)**
  - A full-word write (`sel == 4'hF`) issues an imem write to `IMEM_ADDR`, then `IMEM_ADDR` increments modulo 2^`IMEM_AW`.
  - Partial `sel`: the write is acked and ignored.
  - Reads return 0.
- **0x10 CYCLES (RO)**: 32-bit count of cycles with running = 1; wraps at 2^32.
- **0x14 COREOUT (RO)**: `core_out_i`, sampled at the read.
- Other offsets in the window: acked; reads return 0; writes ignored.

CTRL and IMEM_ADDR honour byte lanes.

Core control:
- running = `RUN & ~DONE`.
- `core_rst_no` = `RUN`, registered. The core is held in reset whenever `RUN` = 0.
- A write to IMEM_DATA while `RUN` = 1 is acked and dropped.

Done handling:
- A rising edge of `core_done_i` while running sets `DONE`.
- `irq_o` = `DONE`.

State machine, states IDLE / IMWR / ACK:
- IDLE → ACK: valid request (`cyc & stb & decode`) other than an IMEM_DATA write.
- IDLE → IMWR: IMEM_DATA write.
- IMWR → ACK: `imem_wr_ready_i` = 1.
- ACK → IDLE: always.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `core_rst_no`=0, `imem_wr_en_o`=0, `imem_wr_addr_o`=0, `imem_wr_data_o`=0, `irq_o`=0. All registers are 0.
- Register read/write: request first sampled at edge N; `wbs_ack_o` is high for exactly cycle N+1; register updates are visible at N+1.
- Ack is never asserted on back-to-back cycles. Minimum transfer spacing is 2 cycles.
- IMEM_DATA write:
  - `imem_wr_en_o` rises at N+1 with address and data stable.
  - It is held until the edge where `ready` = 1.
  - Ack is asserted the cycle after that edge; `IMEM_ADDR` increments in that same cycle.
- `core_done_i` edge at N, with no clear write at N → `DONE` and `irq_o` = 1 at N+1.
- Simultaneous done edge and clear write: set wins.
- `SRST` with a simultaneous done edge: `SRST` wins.
- `CYCLES` freezes on the cycle `DONE` sets.
- Reset asserted mid-transfer: all outputs return to their reset values immediately. The master sees no ack.

## Configuration
- `RV32I_WB_CYCLE_CNT_EN` defined: the CYCLES counter is present as specified.
- Macro undefined: no counter flops are built; 0x10 reads 0 and is still acked.

## Structure
- Shared package `rv32i_wb_pkg` holds:
  - register offset constants (`CTRL_OFF` … `COREOUT_OFF`);
  - CTRL/STATUS bit-index constants;
  - the FSM state enum.
- One sub-module, `rv32i_cycle_counter`: enable, synchronous clear, 32-bit count. It is instantiated only under the macro.

## Test plan
- **Reset:** release reset → all outputs 0; read 0x04 → 0.
- **Imem load with stall:**
  - Write 0x08 = 0x10, then 0x0C = 0xDEADBEEF with `ready` low for 3 cycles.
  - Required: `imem_wr_en_o` high 4 cycles with addr 0x10 and data 0xDEADBEEF; single ack; read 0x08 → 0x11.
- **Wrap and partial write:**
  - `IMEM_ADDR` = 0xFF, full IMEM_DATA write → addr reads 0x00.
  - Write with `sel` = 4'h3 → acked, no `imem_wr_en_o`.
- **Run and done:**
  - Write CTRL = 1 → `core_rst_no` = 1.
  - Pulse `core_done_i` after 100 cycles → `irq_o` = 1; STATUS = 0x2.
  - CYCLES reads 100 with the macro defined, 0 without.
- **Clear vs. set:** write 0x04 = 0x2 on the same edge as a done rising edge → `DONE` stays 1. Writing CTRL = 2 then clears `DONE`, `RUN` and CYCLES.
- **Decode:**
  - Access 0x3000_0100 → no ack.
  - Read 0x3000_0014 with `core_out_i` = 0x12345678 → `wbs_dat_o` = 0x12345678.

Source files
------------

// File: rtl/rv32i_wb_pkg.sv
// rv32i_wb_pkg: register offsets, CTRL/STATUS bit indices and FSM states for rv32i_wb_ctrl.
package rv32i_wb_pkg;

    localparam logic [7:0] CTRL_OFF      = 8'h00;
    localparam logic [7:0] STATUS_OFF    = 8'h04;
    localparam logic [7:0] IMEM_ADDR_OFF = 8'h08;
    localparam logic [7:0] IMEM_DATA_OFF = 8'h0C;
    localparam logic [7:0] CYCLES_OFF    = 8'h10;
    localparam logic [7:0] COREOUT_OFF   = 8'h14;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_SRST_BIT = 1;
    localparam int ST_RUN_BIT    = 0;
    localparam int ST_DONE_BIT   = 1;
    localparam int ST_PEND_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IMWR,
        ST_ACK
    } wb_state_e;

endpackage

// File: rtl/rv32i_cycle_counter.sv
// rv32i_cycle_counter: 32-bit wrapping run-cycle counter with enable and synchronous clear.
module rv32i_cycle_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? 32'd0 : en_i ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= 32'd0;
        else         cnt_q <= cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rv32i_wb_ctrl.sv
// rv32i_wb_ctrl: Wishbone slave that loads imem, runs/stops the rv32i core and reports status.
// Define RV32I_WB_CYCLE_CNT_EN to build the CYCLES run-cycle counter.
module rv32i_wb_ctrl
    import rv32i_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IMEM_AW   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               core_rst_no,
    output logic               imem_wr_en_o,
    output logic [IMEM_AW-1:0] imem_wr_addr_o,
    output logic [31:0]        imem_wr_data_o,
    input  logic               imem_wr_ready_i,
    input  logic [31:0]        core_out_i,
    input  logic               core_done_i,
    output logic               irq_o
);

    wb_state_e          state_q, state_d;
    logic               run_q, run_d;
    logic               done_q, done_d;
    logic               done_prev_q;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [IMEM_AW-1:0] wa_q, wa_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        dat_q, dat_d;

    logic [7:0]  off;
    logic        acc, wr, imwr_go, ctrl_wr, srst, clr, running, set_done, imem_busy;
    logic [31:0] mask, status, rdata, cycles;

    assign off       = wbs_adr_i[7:0];
    assign acc       = (state_q == ST_IDLE) & wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr        = acc & wbs_we_i;
    assign imem_busy = (state_q == ST_IMWR);
    assign imwr_go   = wr & (off == IMEM_DATA_OFF) & (wbs_sel_i == 4'hF) & ~run_q;
    assign ctrl_wr   = wr & (off == CTRL_OFF) & wbs_sel_i[0];
    assign srst      = ctrl_wr & wbs_dat_i[CTRL_SRST_BIT];
    assign clr       = wr & (off == STATUS_OFF) & wbs_dat_i[ST_DONE_BIT];
    assign running   = run_q & ~done_q;
    assign set_done  = core_done_i & ~done_prev_q & running;
    assign mask      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

`ifdef RV32I_WB_CYCLE_CNT_EN
    rv32i_cycle_counter u_cnt (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .en_i   (running),
        .clr_i  (srst),
        .cnt_o  (cycles)
    );
`else
    assign cycles = 32'd0;
`endif

    always_comb begin
        status = 32'd0;
        status[ST_RUN_BIT]  = running;
        status[ST_DONE_BIT] = done_q;
        status[ST_PEND_BIT] = imem_busy;
    end

    assign rdata = (off == CTRL_OFF)      ? 32'(run_q)       :
                   (off == STATUS_OFF)    ? status           :
                   (off == IMEM_ADDR_OFF) ? 32'(imem_addr_q) :
                   (off == CYCLES_OFF)    ? cycles           :
                   (off == COREOUT_OFF)   ? core_out_i       : 32'd0;

    // SRST beats a done edge, which in turn beats a STATUS clear on the same edge.
    always_comb begin
        state_d     = (state_q == ST_IDLE) ? (acc ? (imwr_go ? ST_IMWR : ST_ACK) : ST_IDLE) :
                      (state_q == ST_IMWR) ? (imem_wr_ready_i ? ST_ACK : ST_IMWR) : ST_IDLE;
        run_d       = srst ? 1'b0 : ctrl_wr ? wbs_dat_i[CTRL_RUN_BIT] : run_q;
        done_d      = srst ? 1'b0 : set_done ? 1'b1 : clr ? 1'b0 : done_q;
        imem_addr_d = (wr & (off == IMEM_ADDR_OFF)) ?
                          IMEM_AW'((32'(imem_addr_q) & ~mask) | (wbs_dat_i & mask)) :
                      (imem_busy & imem_wr_ready_i) ? imem_addr_q + IMEM_AW'(1) : imem_addr_q;
        wa_d        = imwr_go ? imem_addr_q : wa_q;
        wd_d        = imwr_go ? wbs_dat_i : wd_q;
        dat_d       = (acc & ~wbs_we_i) ? rdata : 32'd0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            done_prev_q <= 1'b0;
            imem_addr_q <= '0;
            wa_q        <= '0;
            wd_q        <= 32'd0;
            dat_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            done_q      <= done_d;
            done_prev_q <= core_done_i;
            imem_addr_q <= imem_addr_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            dat_q       <= dat_d;
        end

    assign wbs_ack_o      = (state_q == ST_ACK);
    assign wbs_dat_o      = dat_q;
    assign core_rst_no    = run_q;
    assign imem_wr_en_o   = imem_busy;
    assign imem_wr_addr_o = wa_q;
    assign imem_wr_data_o = wd_q;
    assign irq_o          = done_q;

endmodule

// File: tb/tb_rv32i_wb_ctrl.sv
// tb_rv32i_wb_ctrl: directed and randomized checks of rv32i_wb_ctrl against a cycle-stepped register model.
module tb_rv32i_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef RV32I_WB_CYCLE_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic        core_rst_n, imem_en, imem_rdy = 1'b1, core_done = 1'b0, irq;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data, core_out = 32'd0;

    rv32i_wb_ctrl dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .wbs_cyc_i       (cyc),
        .wbs_stb_i       (stb),
        .wbs_we_i        (we),
        .wbs_sel_i       (sel),
        .wbs_adr_i       (adr),
        .wbs_dat_i       (wdat),
        .wbs_ack_o       (ack),
        .wbs_dat_o       (rdat),
        .core_rst_no     (core_rst_n),
        .imem_wr_en_o    (imem_en),
        .imem_wr_addr_o  (imem_addr),
        .imem_wr_data_o  (imem_data),
        .imem_wr_ready_i (imem_rdy),
        .core_out_i      (core_out),
        .core_done_i     (core_done),
        .irq_o           (irq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, acks = 0, en_cnt = 0, stall_left = 0;
    bit rand_on = 1'b0, last_acked;

    // Model state: what the registers and outputs must hold after the latest edge.
    bit          m_run, m_done, m_prev, m_pend, m_ack, r_live;
    logic [7:0]  m_addr, m_wa;
    logic [31:0] m_wd, m_cyc, m_dat;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic mreset();
        m_run = 0; m_done = 0; m_prev = 0; m_pend = 0; m_ack = 0; r_live = 0;
        m_addr = 0; m_wa = 0; m_wd = 0; m_cyc = 0; m_dat = 0;
    endtask

    function automatic logic [31:0] mread(input logic [7:0] o, input bit runn);
        case (o)
            8'h00:   return {31'd0, m_run};
            8'h04:   return {29'd0, m_pend, m_done, runn};
            8'h08:   return {24'd0, m_addr};
            8'h10:   return m_cyc;
            8'h14:   return core_out;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: derive the next model state from the inputs presented now, clock, then compare.
    task automatic step();
        bit runn, srst, clr, n_run, n_done, n_pend, n_ack;
        logic [7:0]  n_addr, o;
        logic [31:0] n_cyc, n_dat;
        if (stall_left > 0) begin imem_rdy = 1'b0; stall_left--; end
        else imem_rdy = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rand_on) begin
            core_done = ($urandom_range(0, 9) == 0);
            core_out  = $urandom;
        end
        runn = m_run & ~m_done;
        srst = 0; clr = 0; n_run = m_run; n_pend = m_pend; n_ack = 0; n_addr = m_addr; n_dat = 0;
        n_cyc = (CNT && runn) ? m_cyc + 1 : m_cyc;
        if (m_pend) begin
            if (imem_rdy) begin n_pend = 0; n_addr = m_addr + 8'd1; n_ack = 1; end
        end else if (r_live && cyc && stb && adr[31:8] == BASE[31:8]) begin
            r_live = 0;
            o = adr[7:0];
            if (!we) begin
                n_ack = 1; n_dat = mread(o, runn);
            end else if (o == 8'h0C && sel == 4'hF && !m_run) begin
                n_pend = 1; m_wa = m_addr; m_wd = wdat;
            end else begin
                n_ack = 1;
                if (o == 8'h00 && sel[0]) begin n_run = wdat[0]; srst = wdat[1]; end
                if (o == 8'h04) clr = wdat[1];
                if (o == 8'h08 && sel[0]) n_addr = wdat[7:0];
            end
        end
        n_done = srst ? 1'b0 : (core_done && !m_prev && runn) ? 1'b1 : clr ? 1'b0 : m_done;
        if (srst) begin n_run = 0; n_cyc = 0; end
        m_prev = core_done;
        @(posedge clk);
        #1;
        m_run = n_run; m_done = n_done; m_pend = n_pend; m_ack = n_ack;
        m_addr = n_addr; m_cyc = n_cyc; m_dat = n_dat;
        if (ack) acks++;
        if (imem_en) en_cnt++;
        chk("ack", ack, m_ack);
        chk("dat_o", rdat, m_dat);
        chk("irq", irq, m_done);
        chk("core_rst_n", core_rst_n, m_run);
        chk("imem_en", imem_en, m_pend);
        if (m_pend) begin
            chk("imem_addr", imem_addr, m_wa);
            chk("imem_data", imem_data, m_wd);
        end
    endtask

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; r_live = 1;
        last_acked = 0; rd = 32'd0;
        for (int i = 0; i < 40 && !last_acked; i++) begin
            step();
            if (ack) begin last_acked = 1; rd = rdat; end
        end
        chk("ack_seen", 32'(last_acked), 32'(a[31:8] == BASE[31:8]));
        cyc = 0; stb = 0; we = 0; r_live = 0;
        step();
    endtask

    logic [31:0] rd;
    int a0;

    initial begin
        mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_imem_en", imem_en, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_data", imem_data, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1;
        step();
        wb(0, BASE + 32'h04, 0, 4'hF, rd);
        chk("status_after_reset", rd, 0);

        wb(1, BASE + 32'h08, 32'h10, 4'hF, rd);
        en_cnt = 0; a0 = acks; stall_left = 4;
        wb(1, BASE + 32'h0C, 32'hDEADBEEF, 4'hF, rd);
        chk("stall_en_cycles", en_cnt, 4);
        chk("stall_single_ack", acks - a0, 1);
        wb(0, BASE + 32'h08, 0, 4'hF, rd);
        chk("addr_incr", rd, 32'h11);

        wb(1, BASE + 32'h08, 32'hFF, 4'hF, rd);
        wb(1, BASE + 32'h0C, 32'h1234ABCD, 4'hF, rd);
        wb(0, BASE + 32'h08, 0, 4'hF, rd);
        chk("addr_wrap", rd, 32'h0);
        en_cnt = 0;
        wb(1, BASE + 32'h0C, 32'h55555555, 4'h3, rd);
        chk("partial_acked", 32'(last_acked), 1);
        chk("partial_no_en", en_cnt, 0);

        wb(1, BASE + 32'h00, 32'h1, 4'hF, rd);
        chk("run_core_rst_n", core_rst_n, 1);
        repeat (98) step();
        core_done = 1;
        step();
        core_done = 0;
        step();
        chk("done_irq", irq, 1);
        wb(0, BASE + 32'h04, 0, 4'hF, rd);
        chk("status_done", rd, 32'h2);
        wb(0, BASE + 32'h10, 0, 4'hF, rd);
        chk("cycles_100", rd, CNT ? 32'd100 : 32'd0);

        wb(1, BASE + 32'h00, 32'h2, 4'hF, rd);
        wb(1, BASE + 32'h00, 32'h1, 4'hF, rd);
        repeat (5) step();
        core_done = 1;
        wb(1, BASE + 32'h04, 32'h2, 4'hF, rd);
        core_done = 0;
        chk("set_beats_clear", irq, 1);
        wb(1, BASE + 32'h00, 32'h2, 4'hF, rd);
        chk("srst_irq", irq, 0);
        chk("srst_core_rst_n", core_rst_n, 0);
        wb(0, BASE + 32'h10, 0, 4'hF, rd);
        chk("srst_cycles", rd, 0);
        wb(0, BASE + 32'h00, 0, 4'hF, rd);
        chk("srst_ctrl", rd, 0);

        wb(0, 32'h3000_0100, 0, 4'hF, rd);
        chk("decode_miss", 32'(last_acked), 0);
        core_out = 32'h12345678;
        wb(0, BASE + 32'h14, 0, 4'hF, rd);
        chk("coreout", rd, 32'h12345678);

        wb(1, BASE + 32'h08, 32'h5A, 4'hF, rd);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h0C; wdat = 32'hCAFEF00D; sel = 4'hF;
        r_live = 1; stall_left = 100;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_en", imem_en, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_data", imem_data, 0);
        chk("mid_rst_dat", rdat, 0);
        cyc = 0; stb = 0; we = 0; stall_left = 0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_ack", ack, 0);
        rst_n = 1;
        repeat (2) step();

        rand_on = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: wb(0, BASE + {27'd0, 3'($urandom_range(0, 7)), 2'b00}, 0, 4'hF, rd);
                1: wb(1, BASE, ($urandom_range(0, 5) == 0) ? 32'h2 : 32'($urandom_range(0, 1)),
                      4'($urandom), rd);
                2: wb(1, BASE + 32'h04, $urandom, 4'hF, rd);
                3: wb(1, BASE + 32'h08, $urandom, 4'($urandom), rd);
                4: wb(1, BASE + 32'h0C, $urandom, $urandom_range(0, 1) ? 4'hF : 4'($urandom), rd);
                default: repeat ($urandom_range(1, 5)) step();
            endcase
        end
        rand_on = 0;
        core_done = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
